// File: rtl/fir_out_quant_fifo.sv
// FIR output stage: round-half-up arithmetic shift, saturate to OUT_W, then buffer in a FWFT FIFO.
// Optional macro FIR_OUT_SATCNT_EN adds a saturating 16-bit count of clipped words written.
module fir_out_quant_fifo #(
  parameter int IN_W    = 38,
  parameter int OUT_W   = 16,
  parameter int DEPTH   = 16,
  parameter int SHIFT_W = 5,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    din,
  input  logic               din_valid,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [LW-1:0]      level,
  output logic               full,
  output logic               empty,
  output logic               sat,
  output logic               ovf,
  input  logic               clr_ovf
`ifdef FIR_OUT_SATCNT_EN
  ,
  output logic [15:0]        sat_cnt
`endif
);

  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  // Stage 1: quantiser
  logic signed [IN_W:0] ext, rnd_add, sum, shr;
  logic [OUT_W-1:0]     q_word;
  logic                 q_sat;

  always_comb begin
    ext     = {din[IN_W-1], din};
    rnd_add = '0;
    if (shift != '0) rnd_add = (IN_W+1)'(1) << (shift - SHIFT_W'(1));
    sum     = ext + rnd_add;
    shr     = sum >>> shift;
    q_word  = shr[OUT_W-1:0];
    q_sat   = 1'b0;
    if (shr > MAX_V) begin
      q_word = {1'b0, {(OUT_W-1){1'b1}}};
      q_sat  = 1'b1;
    end else if (shr < MIN_V) begin
      q_word = {1'b1, {(OUT_W-1){1'b0}}};
      q_sat  = 1'b1;
    end
  end

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_data_q;
  logic             s1_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= din_valid;
      if (din_valid) begin
        s1_data_q <= q_word;
        s1_sat_q  <= q_sat;
      end
    end
  end

  // Stage 2: FIFO. Handshake: a word transfers on every edge where dout_valid && dout_ready;
  // dout_valid never depends on dout_ready, and dout_ready while empty has no effect.
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             sat_q, sat_d, ovf_q, ovf_d;
  logic             push, pop, do_write, drop;

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem[rptr_q];
  assign sat        = sat_q;
  assign ovf        = ovf_q;

  always_comb begin
    push     = s1_valid_q;
    pop      = dout_valid && dout_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    do_write = push && (!full || pop);
    drop     = push && full && !pop;
    wptr_d   = do_write ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
    level_d  = level_q;
    if (do_write && !pop)      level_d = level_q + LW'(1);
    else if (!do_write && pop) level_d = level_q - LW'(1);
    sat_d    = do_write && s1_sat_q;
    ovf_d    = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (do_write && !rst) mem[wptr_q] <= s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIR_OUT_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_ovf)                                        sat_cnt_d = '0;
    else if (do_write && s1_sat_q && sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_out_quant_fifo.sv
// Directed bench for fir_out_quant_fifo: rounding, saturation, fill/overflow, full push+pop, reset.
module tb_fir_out_quant_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [37:0] din;
  logic        din_valid;
  logic [4:0]  shift;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  level;
  logic        full, empty, sat, ovf, clr_ovf;
`ifdef FIR_OUT_SATCNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  fir_out_quant_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .shift      (shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .sat        (sat),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf)
`ifdef FIR_OUT_SATCNT_EN
    ,
    .sat_cnt    (sat_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drivers: all inputs change on the falling edge
  task automatic send(input logic [37:0] d, input logic [4:0] s);
    din = d; shift = s; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic pop_one();
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic drain_check(input string tag, input int n);
    dout_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(dout), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    dout_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; shift = '0; dout_ready = 1'b0; clr_ovf = 1'b0;
    idle(2);
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dvalid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // positive rounding: (0x12345 + 0x80) >> 8 = 0x123
    send(38'h12345, 5'd8);
    check("lat_not_yet", 32'(dout_valid), 32'd0);
    idle(1);
    check("pos_dout", 32'(dout), 32'h0123);
    check("pos_dvalid", 32'(dout_valid), 32'd1);
    check("pos_sat", 32'(sat), 32'd0);
    check("pos_level", 32'(level), 32'd1);
    pop_one();
    check("pos_empty", 32'(empty), 32'd1);

    // negative half rounds up: -384 -> -1, -385 -> -2
    send(38'(-384), 5'd8);
    idle(1);
    check("neg_half", 32'(dout), 32'hFFFF);
    pop_one();
    send(38'(-385), 5'd8);
    idle(1);
    check("neg_below", 32'(dout), 32'hFFFE);
    pop_one();

    // saturation both directions
    send(38'h0040000000, 5'd4);
    idle(1);
    check("sat_pos", 32'(dout), 32'h7FFF);
    check("sat_pos_pulse", 32'(sat), 32'd1);
    idle(1);
    check("sat_pulse_end", 32'(sat), 32'd0);
    pop_one();
    send(38'(-(64'sd1 <<< 30)), 5'd0);
    idle(1);
    check("sat_neg", 32'(dout), 32'h8000);
    check("sat_neg_pulse", 32'(sat), 32'd1);
    pop_one();
`ifdef FIR_OUT_SATCNT_EN
    check("sat_cnt", 32'(sat_cnt), 32'd2);
`endif

    // fill with 17 words, 17th dropped
    for (int i = 1; i <= 17; i++) begin
      din = 38'(i); shift = 5'd0; din_valid = 1'b1;
      if (i <= 16) exp_q.push_back(16'(i));
      @(negedge clk);
    end
    din_valid = 1'b0;
    idle(2);
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    check("fill_ovf", 32'(ovf), 32'd1);
    drain_check("fill_drain", 16);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) begin
      din = 38'(16'h100 + i); din_valid = 1'b1;
      exp_q.push_back(16'(16'h100 + i));
      @(negedge clk);
    end
    din_valid = 1'b0;
    idle(2);
    check("pp_full_before", 32'(full), 32'd1);
    send(38'h200, 5'd0);
    check("pp_head", 32'(dout), 32'(exp_q.pop_front()));
    exp_q.push_back(16'h200);
    pop_one();
    check("pp_level", 32'(level), 32'd16);
    check("pp_full", 32'(full), 32'd1);
    check("pp_ovf", 32'(ovf), 32'd0);
    drain_check("pp_drain", 16);

    // reset with 5 words queued and one in stage 1
    for (int i = 0; i < 6; i++) begin
      din = 38'(16'h30 + i); din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_dvalid", 32'(dout_valid), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    idle(2);
    check("mid_rst_inflight", 32'(level), 32'd0);
    send(38'h55, 5'd0);
    idle(1);
    check("post_rst_dout", 32'(dout), 32'h0055);
    check("post_rst_level", 32'(level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_out_quant_fifo.md
Name: fir_out_quant_fifo

Overview:
Output stage directly downstream of the FIR core, in the core's fast-clock domain. It takes each 38-bit signed accumulator result and its valid strobe, and rounds it half-up with a programmable arithmetic right shift. The result is saturated to 16-bit signed and buffered in a first-word-fall-through FIFO. A valid/ready interface drains the FIFO toward the sink (DAC, UART or log writer).

Parameters:
IN_W, 38, accumulator input width (signed two's complement)
OUT_W, 16, quantised output width (signed)
DEPTH, 16, FIFO depth in words; power of two, at least 2
SHIFT_W, 5, width of shift control (shift range 0..2^SHIFT_W-1)

Ports:
clk  in  1  sole clock; all logic on posedge
rst  in  1  synchronous, active-high reset
din  in  IN_W  accumulator result from FIR core
din_valid  in  1  din qualifier, one-cycle strobe per result
shift  in  SHIFT_W  right-shift amount, sampled together with din
dout  out  OUT_W  head-of-FIFO word; 0 when empty
dout_valid  out  1  FIFO non-empty
dout_ready  in  1  sink accepts dout this cycle
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
full  out  1  level==DEPTH
empty  out  1  level==0
sat  out  1  one-cycle pulse: the word written this cycle was clipped
ovf  out  1  sticky: a quantised word was dropped because the FIFO was full
clr_ovf  in  1  clears ovf

Behaviour:
- Reset (rst=1 at posedge): pointers=0, level=0, empty=1, full=0, dout_valid=0, dout=0, sat=0, ovf=0, stage-1 register and its valid cleared. Reset mid-stream discards the FIFO contents and any in-flight word.
- Stage 1, registered on the edge where din_valid=1: sign-extend din to IN_W+1 bits.
  - shift>0: add 2^(shift-1), then arithmetic right shift by shift.
  - shift=0: pass through unchanged.
  - Clip the result to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; the saturation flag travels with the word.
- Stage 2 (write): a valid stage-1 word is written at mem[wptr] on the next edge, and wptr wraps modulo DEPTH. sat pulses in that write cycle if the word was clipped.
- Latency: din_valid at edge N, then dout_valid=1 after edge N+1 if the FIFO was empty. Back-to-back din_valid is supported at 1 word/cycle.
- Read: FWFT. dout = mem[rptr] whenever !empty. A pop occurs when dout_valid && dout_ready; rptr wraps modulo DEPTH. dout_ready while empty is ignored.
- Push and pop in the same cycle: level is unchanged. This includes the full case, where the push is accepted because the pop frees a slot.
- Push while full with no pop: the word is dropped, ovf is set, and pointers and level are unchanged. sat does not pulse for a dropped word.
- If clr_ovf and a new overflow occur in the same cycle, set wins.
- No combinational path from din to any output. dout_ready affects only state, not same-cycle outputs.

Optional Feature:
FIR_OUT_SATCNT_EN.
- Defined: adds output sat_cnt[15:0], counting written words that were clipped. It saturates at 0xFFFF, resets to 0, and clears when clr_ovf=1 (clear wins over increment).
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Rounding, positive: din=0x0000012345, shift=8 -> dout=0x0123 two edges later, sat=0.
2. Rounding, negative half: din=-384, shift=8 -> dout=0xFFFF (-1.5 rounds to -1). Then din=-385, shift=8 -> 0xFFFE.
3. Saturation: din=2^30, shift=4 -> 0x7FFF with a sat pulse; din=-2^30, shift=0 -> 0x8000 with a sat pulse. With FIR_OUT_SATCNT_EN, sat_cnt=2.
4. Fill and overflow: dout_ready=0, push 17 words 1..17 at shift=0 -> full=1, level=16, ovf=1. Then dout_ready=1 drains 1..16 in order; empty=1 and ovf stays 1 until clr_ovf pulses.
5. Push and pop while full: FIFO full, din_valid=1 and dout_ready=1 in the same cycle -> level stays 16, ovf stays 0, new word appears last.
6. Reset mid-operation: 5 words queued plus one in stage 1; assert rst for one cycle -> level=0, dout=0, dout_valid=0, ovf=0. The next din is output first.
